if_stage_pp: RTL and testbench

- Instruction-fetch stage of the pipelined processor: owns the PC register and the IF/ID pipeline register.
- Drives a word index to the combinational instruction ROM and captures the returned word into IF/ID.
- Honours load-use stalls from the hazard unit and branch redirects resolved in ID.
- Decodes J in IF, so a jump costs no bubble.

---
 rtl/pp_pkg.sv | 28 ++
 rtl/ifid_reg_pp.sv | 37 +++
 rtl/if_stage_pp.sv | 106 ++++++++++
 tb/tb_if_stage_pp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared definitions for the pipelined processor: opcode constants and the
// IF/ID pipeline register payload that both the IF and ID stages use.
package pp_pkg;

    // Opcode field values (instruction bits [31:26]).
    localparam logic [5:0] J_OPCODE     = 6'b000010;
    localparam logic [5:0] BEQ_OPCODE   = 6'b000100;
    localparam logic [5:0] LW_OPCODE    = 6'b100011;
    localparam logic [5:0] SW_OPCODE    = 6'b101011;
    localparam logic [5:0] RTYPE_OPCODE = 6'b000000;

    // All-zero word decodes as an R-type with no writeback: a safe bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // IF/ID payload. pc1 is kept at the full 32 bits so the struct is fixed;
    // narrower PCs are zero-extended into it.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc1;
        logic        valid;
    } ifid_t;

    // Opcode field of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/ifid_reg_pp.sv
// IF/ID pipeline register with bubble (highest priority), load and hold.
module ifid_reg_pp
    import pp_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Next value: bubble wins over load; otherwise hold.
    always_comb begin
        ifid_d = ifid_q;
        if (bubble) begin
            ifid_d = '{instr: NOP_INSTR, pc1: 32'h0, valid: 1'b0};
        end else if (load) begin
            ifid_d = d;
        end
    end

    // Register with asynchronous clear to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{instr: NOP_INSTR, pc1: 32'h0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q = ifid_q;

endmodule

// File: rtl/if_stage_pp.sv
// Instruction-fetch stage: PC register, next-PC selection (branch redirect,
// stall, IF-stage jump, sequential), fetched-instruction counter, and the
// IF/ID register.
//
// Output qualifier: IFID_Valid=1 means IFID_Instr/IFID_PC1 describe a real
// instruction; IFID_Valid=0 is a bubble and the other fields read as zero.
// While Stall is high the register holds, so the same instruction stays
// presented; a new instruction is captured only on an unstalled,
// unbranched edge.
module if_stage_pp
    import pp_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16,
    parameter logic [5:0]      J_OPCODE = pp_pkg::J_OPCODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Instr_In,
    input  logic              Stall,
    input  logic              Branch_Taken,
    input  logic [ADDR_W-1:0] Branch_Target,
    output logic [ADDR_W-1:0] PC_Out,
    output logic [31:0]       IFID_Instr,
    output logic [ADDR_W-1:0] IFID_PC1,
    output logic              IFID_Valid,
    output logic [CNT_W-1:0]  Fetch_Count
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [CNT_W-1:0]  fetch_count_q;
    logic [CNT_W-1:0]  fetch_count_d;
    logic              ifid_load;
    logic              ifid_bubble;
    ifid_t             ifid_in;
    ifid_t             ifid_out;

    // PC is a word index, so sequential fetch is +1 and wraps naturally.
    assign pc_plus1 = pc_q + ADDR_W'(1);

    // Next-PC and IF/ID control, first matching case wins: a branch resolved
    // in ID is older than anything in IF, so it beats both Stall and a J.
    always_comb begin
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (Branch_Taken) begin
            pc_d        = Branch_Target;
            ifid_bubble = 1'b1;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (opcode_of(Instr_In) == J_OPCODE) begin
            pc_d      = ADDR_W'(Instr_In[25:0]);
            ifid_load = 1'b1;
        end else begin
            pc_d      = pc_plus1;
            ifid_load = 1'b1;
        end
    end

    // IF/ID payload for a load; the J itself flows on as a no-writeback op.
    always_comb begin
        ifid_in       = '{instr: NOP_INSTR, pc1: 32'h0, valid: 1'b0};
        ifid_in.instr = Instr_In;
        ifid_in.pc1   = 32'(pc_plus1);
        ifid_in.valid = 1'b1;
    end

    // Count every valid capture into IF/ID, saturating at all-ones.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (ifid_load && (fetch_count_q != {CNT_W{1'b1}})) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    // PC and fetch counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    ifid_reg_pp u_ifid_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_in),
        .q      (ifid_out)
    );

    assign PC_Out      = pc_q;
    assign IFID_Instr  = ifid_out.instr;
    assign IFID_PC1    = ifid_out.pc1[ADDR_W-1:0];
    assign IFID_Valid  = ifid_out.valid;
    assign Fetch_Count = fetch_count_q;

endmodule

// File: tb/tb_if_stage_pp.sv
// Testbench for if_stage_pp: main instance with default widths driven by a
// randomized/directed driver and checked by a queue-based scoreboard, plus a
// narrow instance exercising PC wrap and counter saturation.
module tb_if_stage_pp;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [31:0] instr_in;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc1;
    logic        ifid_valid;
    logic [15:0] fetch_count;

    logic [31:0] rom [0:255];
    assign instr_in = rom[pc_out[7:0]];

    if_stage_pp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Instr_In      (instr_in),
        .Stall         (stall),
        .Branch_Taken  (br),
        .Branch_Target (tgt),
        .PC_Out        (pc_out),
        .IFID_Instr    (ifid_instr),
        .IFID_PC1      (ifid_pc1),
        .IFID_Valid    (ifid_valid),
        .Fetch_Count   (fetch_count)
    );

    // ---------------- narrow DUT (ADDR_W=4, CNT_W=2) ----------------
    logic        s_rst_n;
    logic [31:0] s_instr;
    logic        s_stall;
    logic        s_br;
    logic [3:0]  s_tgt;
    logic [3:0]  s_pc;
    logic [31:0] s_ifid_instr;
    logic [3:0]  s_ifid_pc1;
    logic        s_ifid_valid;
    logic [1:0]  s_cnt;

    // Narrow ROM: word at address p is simply p (opcode 0, never a jump).
    assign s_instr = {28'h0, s_pc};

    if_stage_pp #(.ADDR_W(4), .CNT_W(2)) dut_small (
        .clk           (clk),
        .rst_n         (s_rst_n),
        .Instr_In      (s_instr),
        .Stall         (s_stall),
        .Branch_Taken  (s_br),
        .Branch_Target (s_tgt),
        .PC_Out        (s_pc),
        .IFID_Instr    (s_ifid_instr),
        .IFID_PC1      (s_ifid_pc1),
        .IFID_Valid    (s_ifid_valid),
        .Fetch_Count   (s_cnt)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc1;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc1;
    logic        m_valid;
    int          m_cnt;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc1   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock edge of the fetch stage described in terms of its rules.
    task automatic model_step(input logic st, input logic b, input logic [31:0] t);
        logic [31:0] w;
        if (b) begin
            m_pc    = t;
            m_instr = 32'h0;
            m_pc1   = 32'h0;
            m_valid = 1'b0;
        end else if (!st) begin
            w       = rom[m_pc[7:0]];
            m_instr = w;
            m_pc1   = m_pc + 32'd1;
            m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (w[31:26] == 6'b000010) m_pc = {6'b0, w[25:0]};
            else                       m_pc = m_pc + 32'd1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic st, input logic b, input logic [31:0] t);
        exp_t e;
        stall = st;
        br    = b;
        tgt   = t;
        model_step(st, b, t);
        @(posedge clk);
        #1;
        e.pc    = m_pc;
        e.instr = m_instr;
        e.pc1   = m_pc1;
        e.valid = m_valid;
        e.cnt   = 16'(m_cnt);
        exp_q.push_back(EW'(e));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            chk("pc_out",      64'(pc_out),      64'(e.pc));
            chk("ifid_valid",  64'(ifid_valid),  64'(e.valid));
            chk("ifid_instr",  64'(ifid_instr),  64'(e.instr));
            chk("ifid_pc1",    64'(ifid_pc1),    64'(e.pc1));
            chk("fetch_count", 64'(fetch_count), 64'(e.cnt));
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        logic        rs;
        logic        rb;
        logic [31:0] rt;
        int          p;
        int          k;

        rst_n   = 1'b0;
        s_rst_n = 1'b0;
        stall   = 1'b0;
        br      = 1'b0;
        tgt     = 32'h0;
        s_stall = 1'b1;
        s_br    = 1'b0;
        s_tgt   = 4'h0;

        // ROM: random words, about one in five a jump into the low 256 words.
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(0, 4) == 0) w = {6'b000010, 26'($urandom_range(0, 255))};
            else if (w[31:26] == 6'b000010) w[31:26] = 6'b000000;
            if (i < 32 && w[31:26] == 6'b000010) w[31:26] = 6'b000000;
            rom[i] = w;
        end
        rom[0]  = 32'h0022_1020;
        rom[1]  = 32'h0204_8822;
        rom[12] = 32'h0800_0013;
        model_reset();

        // Reset state, held across clock edges.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_pc",    64'(pc_out),      64'(m_pc));
        chk("reset_instr", 64'(ifid_instr),  64'(m_instr));
        chk("reset_pc1",   64'(ifid_pc1),    64'(m_pc1));
        chk("reset_valid", 64'(ifid_valid),  64'(m_valid));
        chk("reset_cnt",   64'(fetch_count), 64'(m_cnt));
        rst_n = 1'b1;

        // Sequential fetch from word 0 up to PC=5.
        repeat (5) step(1'b0, 1'b0, 32'h0);
        // Stall for two cycles at PC=5, then resume.
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        // Advance to PC=11, then branch to 14 together with Stall.
        repeat (5) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'd14);
        // Early jump at PC=12 to word 19.
        step(1'b0, 1'b1, 32'd12);
        step(1'b0, 1'b0, 32'h0);
        // Same jump discarded by a simultaneous branch to 30.
        step(1'b0, 1'b1, 32'd12);
        step(1'b0, 1'b1, 32'd30);
        // Asynchronous reset between edges at PC=9.
        step(1'b0, 1'b1, 32'd9);
        step(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_pc",    64'(pc_out),      64'(m_pc));
        chk("async_valid", 64'(ifid_valid),  64'(m_valid));
        chk("async_cnt",   64'(fetch_count), 64'(m_cnt));
        chk("async_instr", 64'(ifid_instr),  64'(m_instr));
        #1;
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 32'h0);

        // Randomized phase.
        for (int n = 0; n < 400; n++) begin
            rs = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 6) == 0);
            rt = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(rs, rb, rt);
        end
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // Narrow instance: wrap of the 4-bit PC and saturation of the 2-bit count.
        s_rst_n = 1'b1;
        s_stall = 1'b0;
        s_br    = 1'b1;
        s_tgt   = 4'd14;
        @(posedge clk);
        #1;
        s_br = 1'b0;
        chk("small_br_pc",    64'(s_pc),         64'd14);
        chk("small_br_valid", 64'(s_ifid_valid), 64'd0);
        chk("small_br_cnt",   64'(s_cnt),        64'd0);
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            p = (14 + n - 1) % 16;
            k = (n < 3) ? n : 3;
            chk("small_pc",    64'(s_pc),         64'((14 + n) % 16));
            chk("small_instr", 64'(s_ifid_instr), 64'(p));
            chk("small_pc1",   64'(s_ifid_pc1),   64'((p + 1) % 16));
            chk("small_valid", 64'(s_ifid_valid), 64'd1);
            chk("small_cnt",   64'(s_cnt),        64'(k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
